int_alu_wb_buf: RTL and testbench

Result-side writeback buffer for the integer ALU: accepts the ALU's per-cycle result triple (valid, ROB ID, data), holds results in an in-order FIFO while the common data bus (CDB) is busy, and drives them onto the CDB through a req/gnt handshake with the CDB arbiter. It sits between the ALU execute stage (ex1) and the CDB/ROB writeback, and returns backpressure to ALU issue.

---
 rtl/int_alu_wb_buf.sv | 122 ++++++++++++
 tb/tb_int_alu_wb_buf.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/int_alu_wb_buf.sv
// Integer ALU writeback buffer: in-order result FIFO draining onto the CDB via req/gnt.
// Optional same-cycle ex1->CDB bypass when the buffer is empty: define WB_BYPASS_EN.
module int_alu_wb_buf #(
    parameter int DATA_LEN      = 32,
    parameter int ROB_SIZE_CLOG = 6,
    parameter int WB_DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          alu_result_val_ex1,
    input  logic [ROB_SIZE_CLOG-1:0]      robid_result_ex1,
    input  logic [DATA_LEN-1:0]           result_alu_ex1,
    input  logic                          flush,
    output logic                          alu_wb_rdy,
    output logic                          cdb_req,
    input  logic                          cdb_gnt,
    output logic                          cdb_val_wb,
    output logic [ROB_SIZE_CLOG-1:0]      cdb_robid_wb,
    output logic [DATA_LEN-1:0]           cdb_data_wb,
    output logic [$clog2(WB_DEPTH):0]     wb_cnt,
    output logic                          wb_ovf_err
);

    localparam int PTR_W = $clog2(WB_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ROB_SIZE_CLOG-1:0] r_robid_mem [WB_DEPTH];
    logic [DATA_LEN-1:0]      r_data_mem  [WB_DEPTH];
    logic [PTR_W-1:0]         r_head;
    logic [PTR_W-1:0]         r_tail;
    logic [CNT_W-1:0]         r_cnt;
    logic                     r_ovf;

    logic                     w_rdy;
    logic                     w_empty;
    logic                     w_byp_req;
    logic                     w_req;
    logic                     w_gnt_ok;
    logic                     w_deq;
    logic                     w_byp_take;
    logic                     w_enq;
    logic                     w_drop;
    logic [ROB_SIZE_CLOG-1:0] w_src_robid;
    logic [DATA_LEN-1:0]      w_src_data;

    // Ready comes from the registered count only, so grant never feeds back into issue.
    assign w_rdy   = (r_cnt < CNT_W'(WB_DEPTH));
    assign w_empty = (r_cnt == '0);

`ifdef WB_BYPASS_EN
    assign w_byp_req = alu_result_val_ex1 && w_empty;

    always_comb begin
        w_src_robid = r_robid_mem[r_head];
        w_src_data  = r_data_mem[r_head];
        if (w_empty) begin
            w_src_robid = robid_result_ex1;
            w_src_data  = result_alu_ex1;
        end
    end
`else
    assign w_byp_req = 1'b0;

    always_comb begin
        w_src_robid = r_robid_mem[r_head];
        w_src_data  = r_data_mem[r_head];
    end
`endif

    // No CDB request in a reset or flush cycle: nothing may be broadcast then.
    assign w_req      = !rst && !flush && (!w_empty || w_byp_req);
    assign w_gnt_ok   = w_req && cdb_gnt;
    assign w_deq      = w_gnt_ok && !w_empty;
    assign w_byp_take = w_gnt_ok && w_empty;
    assign w_enq      = alu_result_val_ex1 && w_rdy && !flush && !w_byp_take;
    assign w_drop     = alu_result_val_ex1 && !w_rdy && !flush;

    assign alu_wb_rdy   = w_rdy;
    assign cdb_req      = w_req;
    assign cdb_val_wb   = w_gnt_ok;
    assign cdb_robid_wb = w_req ? w_src_robid : '0;
    assign cdb_data_wb  = w_req ? w_src_data  : '0;
    assign wb_cnt       = r_cnt;
    assign wb_ovf_err   = r_ovf;

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_robid_mem[r_tail] <= robid_result_ex1;
            r_data_mem[r_tail]  <= result_alu_ex1;
        end
    end

    // Pointers wrap naturally since WB_DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head <= '0;
            r_tail <= '0;
            r_cnt  <= '0;
            r_ovf  <= 1'b0;
        end else if (flush) begin
            r_head <= '0;
            r_tail <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_enq) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_deq) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_enq, w_deq})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_int_alu_wb_buf.sv
// Self-checking bench for int_alu_wb_buf: hand-derived vector table plus a queue scoreboard.
module tb_int_alu_wb_buf;

    localparam int DL    = 32;
    localparam int RW    = 6;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          val;
    logic [RW-1:0] robid;
    logic [DL-1:0] data;
    logic          flush;
    logic          rdy;
    logic          req;
    logic          gnt;
    logic          cval;
    logic [RW-1:0] crobid;
    logic [DL-1:0] cdata;
    logic [CW-1:0] cnt;
    logic          ovf;

    int_alu_wb_buf #(.DATA_LEN(DL), .ROB_SIZE_CLOG(RW), .WB_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alu_result_val_ex1(val), .robid_result_ex1(robid), .result_alu_ex1(data),
        .flush(flush), .alu_wb_rdy(rdy), .cdb_req(req), .cdb_gnt(gnt),
        .cdb_val_wb(cval), .cdb_robid_wb(crobid), .cdb_data_wb(cdata),
        .wb_cnt(cnt), .wb_ovf_err(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [RW-1:0] r;
        logic [DL-1:0] d;
    } ent_t;

    typedef struct {
        logic          v;
        logic [RW-1:0] r;
        logic [DL-1:0] d;
        logic          g;
        logic          f;
        logic          e_req;
        logic          e_val;
        logic [RW-1:0] e_robid;
        int            e_cnt;
        logic          e_rdy;
    } vec_t;

    ent_t sbq[$];
    logic m_ovf;
    int   n_chk;
    int   n_err;

    logic          s_req;
    logic          s_val;
    logic [RW-1:0] s_robid;
    int            s_cnt;
    logic          s_rdy;

    task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    // One clock: drive at posedge+1, compare at the following negedge, advance model, cross the edge.
    task automatic step(input int idx, input logic v, input logic [RW-1:0] r, input logic [DL-1:0] d,
                        input logic g, input logic f, input logic rs);
        logic e_req;
        logic e_val;
        logic e_rdy;
        logic empty;
        ent_t src;
        val = v; robid = r; data = d; gnt = g; flush = f; rst = rs;
        #4;
        empty = (sbq.size() == 0);
        e_rdy = (sbq.size() < DEPTH);
        e_req = !rs && !f && (!empty || (BYP && v));
        e_val = e_req && g;
        if (!empty) src = sbq[0];
        else begin
            src.r = r;
            src.d = d;
        end
        s_req = req; s_val = cval; s_robid = crobid; s_cnt = int'(cnt); s_rdy = rdy;
        chk("cdb_req", idx, 64'(req), 64'(e_req));
        chk("cdb_val", idx, 64'(cval), 64'(e_val));
        chk("cdb_robid", idx, 64'(crobid), e_req ? 64'(src.r) : 64'd0);
        chk("cdb_data", idx, 64'(cdata), e_req ? 64'(src.d) : 64'd0);
        chk("wb_cnt", idx, 64'(cnt), 64'(sbq.size()));
        chk("alu_wb_rdy", idx, 64'(rdy), 64'(e_rdy));
        chk("wb_ovf_err", idx, 64'(ovf), 64'(m_ovf));
        if (rs) begin
            sbq.delete();
            m_ovf = 1'b0;
        end else if (f) begin
            sbq.delete();
        end else begin
            if (e_val && !empty) void'(sbq.pop_front());
            if (v) begin
                if (!e_rdy) m_ovf = 1'b1;
                else if (!(BYP && empty && e_val)) begin
                    ent_t e;
                    e.r = r;
                    e.d = d;
                    sbq.push_back(e);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic v, input logic [RW-1:0] r, input logic g, input logic f,
                                input logic e_req, input logic e_val, input logic [RW-1:0] e_robid,
                                input int e_cnt, input logic e_rdy);
        vec_t t;
        t.v = v; t.r = r; t.g = g; t.f = f;
        t.d = (r == 6'd5) ? 32'hDEAD_BEEF : (32'hA500_0000 | 32'(r));
        t.e_req = e_req; t.e_val = e_val; t.e_robid = e_robid; t.e_cnt = e_cnt; t.e_rdy = e_rdy;
        return t;
    endfunction

    vec_t tbl[26];

    initial begin
        n_chk = 0;
        n_err = 0;
        m_ovf = 1'b0;
        val = 1'b0; robid = '0; data = '0; gnt = 1'b0; flush = 1'b0; rst = 1'b1;

        // Expected values below are for the build without the bypass path.
        //            v  rob g  f  req val erob cnt rdy
        tbl[0]  = mk(1, 5,  1, 0, 0,  0,  0,  0,  1);
        tbl[1]  = mk(0, 0,  1, 0, 1,  1,  5,  1,  1);
        tbl[2]  = mk(1, 1,  0, 0, 0,  0,  0,  0,  1);
        tbl[3]  = mk(1, 2,  0, 0, 1,  0,  1,  1,  1);
        tbl[4]  = mk(1, 3,  0, 0, 1,  0,  1,  2,  1);
        tbl[5]  = mk(1, 4,  0, 0, 1,  0,  1,  3,  1);
        tbl[6]  = mk(1, 9,  0, 0, 1,  0,  1,  4,  0);
        tbl[7]  = mk(0, 0,  1, 0, 1,  1,  1,  4,  0);
        tbl[8]  = mk(0, 0,  1, 0, 1,  1,  2,  3,  1);
        tbl[9]  = mk(0, 0,  1, 0, 1,  1,  3,  2,  1);
        tbl[10] = mk(0, 0,  1, 0, 1,  1,  4,  1,  1);
        tbl[11] = mk(0, 0,  1, 0, 0,  0,  0,  0,  1);
        tbl[12] = mk(1, 1,  0, 0, 0,  0,  0,  0,  1);
        tbl[13] = mk(1, 2,  0, 0, 1,  0,  1,  1,  1);
        tbl[14] = mk(1, 3,  1, 0, 1,  1,  1,  2,  1);
        tbl[15] = mk(1, 4,  1, 0, 1,  1,  2,  2,  1);
        tbl[16] = mk(1, 6,  1, 0, 1,  1,  3,  2,  1);
        tbl[17] = mk(0, 0,  1, 0, 1,  1,  4,  2,  1);
        tbl[18] = mk(0, 0,  0, 0, 1,  0,  6,  1,  1);
        tbl[19] = mk(1, 8,  0, 0, 1,  0,  6,  1,  1);
        tbl[20] = mk(1, 10, 0, 0, 1,  0,  6,  2,  1);
        tbl[21] = mk(1, 7,  1, 1, 0,  0,  0,  3,  1);
        tbl[22] = mk(0, 0,  1, 0, 0,  0,  0,  0,  1);
        tbl[23] = mk(1, 11, 1, 0, 0,  0,  0,  0,  1);
        tbl[24] = mk(0, 0,  1, 0, 1,  1,  11, 1,  1);
        tbl[25] = mk(0, 0,  1, 0, 0,  0,  0,  0,  1);

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 10; i++) step(i, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 26; i++) begin
            step(100 + i, tbl[i].v, tbl[i].r, tbl[i].d, tbl[i].g, tbl[i].f, 1'b0);
`ifndef WB_BYPASS_EN
            chk("tbl_req", i, 64'(s_req), 64'(tbl[i].e_req));
            chk("tbl_val", i, 64'(s_val), 64'(tbl[i].e_val));
            chk("tbl_robid", i, 64'(s_robid), 64'(tbl[i].e_robid));
            chk("tbl_cnt", i, 64'(s_cnt), 64'(tbl[i].e_cnt));
            chk("tbl_rdy", i, 64'(s_rdy), 64'(tbl[i].e_rdy));
`endif
        end
        chk("ovf_sticky", 0, 64'(ovf), 64'd1);

        // Reset with two entries buffered and grant high: no broadcast, everything discarded.
        step(200, 1'b1, 6'd12, 32'h1200_0012, 1'b0, 1'b0, 1'b0);
        step(201, 1'b1, 6'd13, 32'h1300_0013, 1'b0, 1'b0, 1'b0);
        step(202, 1'b1, 6'd14, 32'h1400_0014, 1'b1, 1'b0, 1'b1);
        chk("rst_cval", 0, 64'(s_val), 64'd0);
        step(203, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        chk("rst_cnt", 0, 64'(s_cnt), 64'd0);
        chk("rst_ovf", 0, 64'(ovf), 64'd0);

        for (int i = 0; i < 400; i++) begin
            step(1000 + i, ($urandom_range(0, 3) != 0), RW'($urandom_range(0, 63)), $urandom,
                 1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0), 1'b0);
        end

        for (int i = 0; i < 8; i++) step(2000 + i, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        chk("drain_cnt", 0, 64'(cnt), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
